sram_line_fetcher: RTL and testbench
====================================

// Module: sram_line_fetcher
// PURPOSE
//  Parametrised SRAM-to-FIFO scanline prefetcher in the clk100 domain; feeds the write side of the dual-clock pixel FIFO ahead of each active line.
//  On a line request it computes BASE_ADDR + line*LINE_WORDS and issues LINE_WORDS sequential SRAM reads.
//  Each read is pushed only when its data is valid, READ_LATENCY cycles after issue.
//  Issue is throttled by FIFO fill level so no word is ever dropped.
// PARAMETERS
//  ADDR_W        18    SRAM word-address width
//  DATA_W        16    SRAM/FIFO data width
//  LINE_W        10    width of line index
//  LINE_WORDS    800   words fetched per line (>=1)
//  BASE_ADDR     0     framebuffer start address (ADDR_W bits)
//  READ_LATENCY  1     cycles from address issue to valid ram_din (1..4)
//  FIFO_AW       10    width of fifo_wrusedw; FIFO depth = 2**FIFO_AW
//  FIFO_MARGIN   4     extra free slots reserved to cover usedw reporting lag
// PORTS
//  clk100        in   1        sole clock; all logic on posedge
//  rst_n         in   1        asynchronous active-low reset
//  line_req      in   1        request fetch of line_idx (sampled when busy=0)
//  line_idx      in   LINE_W   display line to fetch
//  busy          out  1        fetch in progress (ISSUE or DRAIN)
//  line_done     out  1        one-cycle pulse after last word pushed
//  overrun       out  1        sticky: line_req seen while busy; cleared only by reset
//  ram_addr      out  ADDR_W   SRAM address
//  ram_din       in   DATA_W   SRAM read data
//  ram_ce,ram_oe out  1        chip/output enable, high while issuing
//  ram_we        out  1        constant 0 (read-only block)
//  ram_lb,ram_hb out  1        constant 1
//  fifo_data     out  DATA_W   FIFO write data
//  fifo_wrreq    out  1        FIFO write strobe
//  fifo_wrusedw  in   FIFO_AW  FIFO write-side fill level
// BEHAVIOUR
//  Reset: state IDLE; busy, line_done, overrun, ram_ce, ram_oe, ram_we, fifo_wrreq = 0; ram_addr, fifo_data = 0; in-flight pipe cleared.
//  Reset mid-fetch abandons the line immediately; in-flight reads are discarded, never pushed.
//  IDLE: line_req=1 -> ram_addr <= BASE_ADDR + eff_line*LINE_WORDS (mod 2**ADDR_W), issue_cnt <= 0, -> ISSUE.
//  ISSUE: can_issue = (fifo_wrusedw + inflight) < (2**FIFO_AW - FIFO_MARGIN), compared at FIFO_AW+3 bits.
//    Cycle with can_issue: ram_ce=ram_oe=1, read issued at current ram_addr; ram_addr+1 (wraps at 2**ADDR_W); issue_cnt+1.
//    Cycle without can_issue: ram_ce/ram_oe drop to 0, address held, no valid token inserted.
//    Read issued at edge E: ram_din sampled at edge E+READ_LATENCY; fifo_data/fifo_wrreq registered there, visible one cycle later.
//    After the LINE_WORDS-th issue -> DRAIN; ram_ce/ram_oe drop on the same edge.
//  DRAIN: wait until the in-flight count is 0 and the last push has been made -> IDLE with line_done=1 for one cycle.
//  busy=1 in ISSUE and DRAIN. line_req during busy is ignored and sets overrun; a line_req in the cycle line_done pulses is accepted (state is IDLE).
//  Exactly LINE_WORDS fifo_wrreq pulses per accepted request, in address order, with no gaps other than throttling.
//  Pushes never depend on fifo_wrfull; throttling is the only overflow guard.
// CONFIGURATION
//  LINE_DOUBLE_EN defined: eff_line = line_idx>>1; each framebuffer line is fetched for two consecutive display lines (half vertical resolution).
//  LINE_DOUBLE_EN undefined: eff_line = line_idx.
// STRUCTURE
//  video_pkg: fetch state enum {IDLE, ISSUE, DRAIN}; RGB444 field constants; default address/data widths.
//  Sub-module read_pipe_tracker: READ_LATENCY-deep valid shift register plus in-flight counter; outputs push strobe and inflight.
//  Top level holds the FSM, address generator (constant multiply, shift-add allowed) and FIFO-side output registers.
// TESTING
//  Default params, line_idx=2, fifo_wrusedw=0, ram_din=address model -> first ram_addr 1600; 800 pushes with data 1600..2399; line_done once.
//  READ_LATENCY=3 -> fifo_data equals the address issued 3 cycles earlier; no push of stale data before the first valid word.
//  fifo_wrusedw held at 1020 (FIFO_AW=10) -> ram_ce low, no issue; release to 0 -> fetch resumes at held address, total still 800.
//  line_req pulse while busy -> ignored, overrun=1 and stays 1; line_req on the line_done cycle -> accepted.
//  rst_n low at word 400 -> all outputs 0 asynchronously; no further fifo_wrreq; a new request after release fetches from the line base.
//  LINE_DOUBLE_EN, line_idx 6 and 7 -> both start at ram_addr 2400; BASE_ADDR=2**18-10, line 0 -> address wraps to 0 after 10 words.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video fetch path: fetch FSM states,
// RGB444 pixel field positions and default SRAM address/data widths.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;

    // RGB444 packing inside a 16-bit framebuffer word (top nibble unused)
    localparam int RGB_R_MSB = 11;
    localparam int RGB_R_LSB = 8;
    localparam int RGB_G_MSB = 7;
    localparam int RGB_G_LSB = 4;
    localparam int RGB_B_MSB = 3;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/sram_line_fetcher_read_pipe_tracker.sv
// Tracks SRAM reads in flight: a READ_LATENCY-deep valid pipe whose tail marks
// the edge where ram_din holds valid data, plus a count of reads not yet sampled.
module read_pipe_tracker #(
    parameter int READ_LATENCY = 1,
    parameter int INF_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic             push,
    output logic [INF_W-1:0] inflight
);

    logic [READ_LATENCY-1:0] valid_reg;
    logic [INF_W-1:0]        count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                valid_reg[i] <= valid_reg[i-1];
            end
            valid_reg[0] <= issue;
            count_reg    <= count_reg + INF_W'(issue) - INF_W'(push);
        end
    end

    assign push     = valid_reg[READ_LATENCY-1];
    assign inflight = count_reg;

endmodule

// File: rtl/sram_line_fetcher.sv
// Scanline prefetcher: reads one framebuffer line from SRAM into the pixel FIFO,
// throttled by FIFO fill level. Define LINE_DOUBLE_EN to fetch each line twice.
module sram_line_fetcher
    import video_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                LINE_W       = 10,
    parameter int                LINE_WORDS   = 800,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                READ_LATENCY = 1,
    parameter int                FIFO_AW      = 10,
    parameter int                FIFO_MARGIN  = 4
) (
    input  logic               clk100,
    input  logic               rst_n,
    input  logic               line_req,
    input  logic [LINE_W-1:0]  line_idx,
    output logic               busy,
    output logic               line_done,
    output logic               overrun,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0]  ram_din,
    output logic               ram_ce,
    output logic               ram_oe,
    output logic               ram_we,
    output logic               ram_lb,
    output logic               ram_hb,
    output logic [DATA_W-1:0]  fifo_data,
    output logic               fifo_wrreq,
    input  logic [FIFO_AW-1:0] fifo_wrusedw
);

    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int INF_W = 3;
    localparam logic [FIFO_AW+2:0] ISSUE_LIMIT = (FIFO_AW+3)'(2**FIFO_AW - FIFO_MARGIN);
    localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(LINE_WORDS - 1);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              done_reg, done_next;
    logic              overrun_reg;
    logic [DATA_W-1:0] fifo_data_reg;
    logic              fifo_wrreq_reg;

    logic              issue;
    logic              can_issue;
    logic              push;
    logic [INF_W-1:0]  inflight;
    logic [LINE_W-1:0] eff_line;
    logic [ADDR_W-1:0] line_base;

`ifdef LINE_DOUBLE_EN
    assign eff_line = line_idx >> 1;
`else
    assign eff_line = line_idx;
`endif

    // Multiply at ADDR_W width so the start address wraps modulo the SRAM size
    assign line_base = BASE_ADDR + ADDR_W'(eff_line) * ADDR_W'(LINE_WORDS);

    // Reads still in flight will land in the FIFO, so they count as occupied
    assign can_issue = ({3'b000, fifo_wrusedw} + (FIFO_AW+3)'(inflight)) < ISSUE_LIMIT;
    assign issue     = (state_reg == ISSUE) && can_issue;

    read_pipe_tracker #(
        .READ_LATENCY (READ_LATENCY),
        .INF_W        (INF_W)
    ) u_tracker (
        .clk      (clk100),
        .rst_n    (rst_n),
        .issue    (issue),
        .push     (push),
        .inflight (inflight)
    );

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (line_req) begin
                    addr_next  = line_base;
                    cnt_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_next = addr_reg + 1'b1;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_WORD) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            fifo_data_reg  <= '0;
            fifo_wrreq_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            cnt_reg        <= cnt_next;
            done_reg       <= done_next;
            fifo_wrreq_reg <= push;
            if (push) begin
                fifo_data_reg <= ram_din;
            end
            if (line_req && state_reg != IDLE) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign busy       = (state_reg != IDLE);
    assign line_done  = done_reg;
    assign overrun    = overrun_reg;
    assign ram_addr   = addr_reg;
    assign ram_ce     = issue;
    assign ram_oe     = issue;
    assign ram_we     = 1'b0;
    assign ram_lb     = 1'b1;
    assign ram_hb     = 1'b1;
    assign fifo_data  = fifo_data_reg;
    assign fifo_wrreq = fifo_wrreq_reg;

endmodule

// File: tb/tb_sram_line_fetcher.sv
// Two fetchers (800 words/latency 1/base 0 and 24 words/latency 3/base near top
// of SRAM) checked every cycle against a transaction-level model of the fetch.
module tb_sram_line_fetcher;

    logic clk;
    logic rst_n;
    logic req_a, req_b;
    logic [9:0] idx_a, idx_b;
    logic [9:0] used_a, used_b;
    logic [1:0][15:0] ram_din;

    wire [1:0]       line_req = {req_b, req_a};
    wire [1:0][9:0]  line_idx = {idx_b, idx_a};
    wire [1:0][9:0]  wrusedw  = {used_b, used_a};
    wire [1:0]       busy, line_done, overrun, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, fifo_wrreq;
    wire [1:0][17:0] ram_addr;
    wire [1:0][15:0] fifo_data;

    int total = 0;
    int bad   = 0;

`ifdef LINE_DOUBLE_EN
    localparam int FIRST_LINE = 6,  FIRST_ADDR = 2400;
    localparam int SECOND_LINE = 10, SECOND_ADDR = 4000;
    localparam int RESTART_LINE = 7, RESTART_ADDR = 2400;
`else
    localparam int FIRST_LINE = 2,  FIRST_ADDR = 1600;
    localparam int SECOND_LINE = 5, SECOND_ADDR = 4000;
    localparam int RESTART_LINE = 3, RESTART_ADDR = 2400;
`endif

    sram_line_fetcher dut_a (
        .clk100(clk), .rst_n(rst_n), .line_req(line_req[0]), .line_idx(line_idx[0]),
        .busy(busy[0]), .line_done(line_done[0]), .overrun(overrun[0]),
        .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_ce(ram_ce[0]), .ram_oe(ram_oe[0]),
        .ram_we(ram_we[0]), .ram_lb(ram_lb[0]), .ram_hb(ram_hb[0]),
        .fifo_data(fifo_data[0]), .fifo_wrreq(fifo_wrreq[0]), .fifo_wrusedw(wrusedw[0])
    );

    sram_line_fetcher #(
        .LINE_WORDS(24), .READ_LATENCY(3), .BASE_ADDR(18'(262134))
    ) dut_b (
        .clk100(clk), .rst_n(rst_n), .line_req(line_req[1]), .line_idx(line_idx[1]),
        .busy(busy[1]), .line_done(line_done[1]), .overrun(overrun[1]),
        .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_ce(ram_ce[1]), .ram_oe(ram_oe[1]),
        .ram_we(ram_we[1]), .ram_lb(ram_lb[1]), .ram_hb(ram_hb[1]),
        .fifo_data(fifo_data[1]), .fifo_wrreq(fifo_wrreq[1]), .fifo_wrusedw(wrusedw[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rl_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction
    function automatic int lw_of(input int d);
        return (d == 1) ? 24 : 800;
    endfunction
    function automatic int base_of(input int d);
        return (d == 1) ? 262134 : 0;
    endfunction
    function automatic int eff_of(input int idx);
`ifdef LINE_DOUBLE_EN
        return idx >> 1;
`else
        return idx;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          edge_no = 16;
    bit          iss_v [2][8];
    logic [17:0] iss_a [2][8];
    bit          exp_busy [2], exp_ovr [2], done_pend [2], pend_acc [2], pend_ovr [2];
    int          words_iss [2], words_push [2], line_no [2];
    int          push_cnt [2], done_cnt [2];
    logic [17:0] next_addr [2], pend_base [2];
    logic [17:0] b_log [32];
    logic [15:0] b_first_data;
    bit          b_first_seen;

    initial begin
        for (int d = 0; d < 2; d++) begin
            line_no[d] = 0; push_cnt[d] = 0; done_cnt[d] = 0;
        end
        b_first_seen = 0;
        b_first_data = '0;
    end

    always @(negedge clk) begin
        edge_no++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) iss_v[d][k] = 0;
                exp_busy[d] = 0; exp_ovr[d] = 0; done_pend[d] = 0;
                pend_acc[d] = 0; pend_ovr[d] = 0;
                words_iss[d] = 0; words_push[d] = 0;
                ram_din[d] = 16'($urandom);
            end else begin
                int  slot, infl;
                bit  exp_wr, exp_done, exp_ce;
                if (pend_acc[d]) begin
                    exp_busy[d] = 1; words_iss[d] = 0; words_push[d] = 0;
                    next_addr[d] = pend_base[d]; pend_acc[d] = 0; line_no[d]++;
                end
                if (pend_ovr[d]) begin
                    exp_ovr[d] = 1; pend_ovr[d] = 0;
                end
                exp_done = done_pend[d];
                done_pend[d] = 0;
                if (exp_done) exp_busy[d] = 0;

                // a read issued at edge E is pushed at E+latency, visible one cycle on
                slot   = (edge_no - rl_of(d) - 1) & 7;
                exp_wr = iss_v[d][slot];
                chk("fifo_wrreq", fifo_wrreq[d], exp_wr);
                if (fifo_wrreq[d]) begin
                    push_cnt[d]++;
                    if (d == 1 && !b_first_seen) begin
                        b_first_seen = 1;
                        b_first_data = fifo_data[1];
                    end
                end
                if (exp_wr) begin
                    chk("fifo_data", fifo_data[d], iss_a[d][slot][15:0]);
                    words_push[d]++;
                    if (words_push[d] == lw_of(d)) done_pend[d] = 1;
                end
                if (line_done[d]) done_cnt[d]++;
                chk("line_done", line_done[d], exp_done);
                chk("busy", busy[d], exp_busy[d]);
                chk("overrun", overrun[d], exp_ovr[d]);
                chk("ram_we", ram_we[d], 0);
                chk("ram_lb_hb", {ram_lb[d], ram_hb[d]}, 3);

                infl = 0;
                for (int j = 1; j <= rl_of(d); j++) infl += int'(iss_v[d][(edge_no - j) & 7]);
                exp_ce = exp_busy[d] && (words_iss[d] < lw_of(d)) && (int'(wrusedw[d]) + infl < 1020);
                chk("ram_ce", ram_ce[d], exp_ce);
                chk("ram_oe", ram_oe[d], exp_ce);
                iss_v[d][edge_no & 7] = exp_ce;
                iss_a[d][edge_no & 7] = next_addr[d];
                if (exp_ce) begin
                    chk("ram_addr", ram_addr[d], next_addr[d]);
                    if (d == 1 && line_no[1] == 1 && words_iss[1] < 32) b_log[words_iss[1]] = ram_addr[1];
                    next_addr[d] = next_addr[d] + 18'd1;
                    words_iss[d]++;
                end

                // SRAM model: data equals its address, garbage when nothing is due
                if (iss_v[d][(edge_no - rl_of(d)) & 7])
                    ram_din[d] = iss_a[d][(edge_no - rl_of(d)) & 7][15:0];
                else
                    ram_din[d] = 16'($urandom);

                if (line_req[d]) begin
                    if (!exp_busy[d]) begin
                        pend_acc[d]  = 1;
                        pend_base[d] = 18'((base_of(d) + eff_of(int'(line_idx[d])) * lw_of(d)) & 32'h3FFFF);
                    end else begin
                        pend_ovr[d] = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus for fetcher B: random lines and fill levels ----------------
    initial begin
        req_b = 0; idx_b = 0; used_b = 0;
        wait (rst_n);
        @(posedge clk); #1;
        idx_b = 0; req_b = 1;
        @(posedge clk); #1;
        req_b = 0;
        forever begin
            @(posedge clk); #1;
            used_b = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1010, 1023)) : 10'($urandom_range(0, 1000));
            idx_b  = 10'($urandom);
            req_b  = busy[1] ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- stimulus for fetcher A: directed scenarios ----------------
    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, busy[d], 0);
            chk({tag, "_done"}, line_done[d], 0);
            chk({tag, "_ovr"}, overrun[d], 0);
            chk({tag, "_ce_oe_we"}, {ram_ce[d], ram_oe[d], ram_we[d]}, 0);
            chk({tag, "_wrreq"}, fifo_wrreq[d], 0);
            chk({tag, "_addr"}, ram_addr[d], 0);
            chk({tag, "_data"}, fifo_data[d], 0);
        end
    endtask

    task automatic wait_done_a(input int max_cyc, input bit rnd);
        bit seen;
        seen = 0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(posedge clk); #1;
            if (rnd) used_a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 900));
            if (line_done[0]) seen = 1;
        end
        chk("line_done_seen", seen, 1);
    endtask

    initial begin
        int p0, d0;
        logic [17:0] hold;
        rst_n = 0; req_a = 0; idx_a = 0; used_a = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1;

        @(posedge clk); #1;
        idx_a = 10'(FIRST_LINE); req_a = 1;
        @(posedge clk); #1;
        req_a = 0;
        chk("first_addr", ram_addr[0], FIRST_ADDR);
        chk("busy_after_req", busy[0], 1);
        p0 = push_cnt[0]; d0 = done_cnt[0];

        repeat (100) @(posedge clk);
        #1; idx_a = 9; req_a = 1;
        @(posedge clk); #1;
        req_a = 0;
        chk("overrun_set", overrun[0], 1);

        wait_done_a(2000, 0);
        chk("pushes_line1", push_cnt[0] - p0, 800);
        idx_a = 10'(SECOND_LINE); req_a = 1;
        p0 = push_cnt[0];
        @(posedge clk); #1;
        req_a = 0;
        chk("done_once", done_cnt[0] - d0, 1);
        chk("done_one_cycle", line_done[0], 0);
        chk("second_addr", ram_addr[0], SECOND_ADDR);

        repeat (50) @(posedge clk);
        #1; used_a = 10'd1020;
        @(posedge clk); #1;
        hold = ram_addr[0];
        repeat (20) @(posedge clk);
        #1;
        chk("throttle_ce", ram_ce[0], 0);
        chk("throttle_hold", ram_addr[0], hold);
        used_a = 0;
        wait_done_a(6000, 1);
        used_a = 0;
        chk("pushes_line2", push_cnt[0] - p0, 800);

        @(posedge clk); #1;
        idx_a = 1; req_a = 1;
        @(posedge clk); #1;
        req_a = 0;
        p0 = push_cnt[0];
        for (int n = 0; n < 2000 && (push_cnt[0] - p0) < 400; n++) @(posedge clk);
        chk("reached_400", (push_cnt[0] - p0) >= 400, 1);
        #3;
        chk("overrun_sticky", overrun[0], 1);
        rst_n = 0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        #3; rst_n = 1;
        p0 = push_cnt[0];
        repeat (6) @(posedge clk);
        #1;
        chk("no_push_after_rst", push_cnt[0] - p0, 0);
        idx_a = 10'(RESTART_LINE); req_a = 1;
        @(posedge clk); #1;
        req_a = 0;
        chk("restart_addr", ram_addr[0], RESTART_ADDR);
        p0 = push_cnt[0];
        wait_done_a(2000, 0);
        chk("pushes_restart", push_cnt[0] - p0, 800);
`ifdef LINE_DOUBLE_EN
        idx_a = 6; req_a = 1;
        @(posedge clk); #1;
        req_a = 0;
        chk("double_addr", ram_addr[0], 2400);
        wait_done_a(2000, 0);
`endif

        chk("b_first_addr", b_log[0], 262134);
        chk("b_wrap_addr", b_log[10], 0);
        chk("b_after_wrap", b_log[11], 1);
        chk("b_first_data", b_first_data, 16'hFFF6);
        chk("b_lines_done", done_cnt[1] > 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
